// File: rtl/motor_step_sequencer_if.sv
// Queue-walk and motor driver signals between the top-level FSM/queue builder
// (master) and the step sequencer (slave).
interface motor_step_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   q_len;
  logic [ADDR_W-1:0] q_addr;
  logic [3:0]        q_data;
  logic [5:0]        step_o;
  logic              dir_o;
  logic [5:0]        motor_en_o;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   moves_done;

  modport master (
    output start, abort, q_len, q_data,
    input  q_addr, step_o, dir_o, motor_en_o, busy, done, err, moves_done
  );

  modport slave (
    input  start, abort, q_len, q_data,
    output q_addr, step_o, dir_o, motor_en_o, busy, done, err, moves_done
  );
endinterface

// File: rtl/motor_step_sequencer.sv
// Walks the move queue and drives one stepper motor at a time: DIR setup,
// a fixed burst of STEP pulses, then a settle gap before the next entry.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD     | decode queue entry at q_addr (skip code 7, stop on code 0)
// SETUP    | DIR stable, motor enabled, no steps yet
// PULSE_HI | step_o[sel] high for one half-period
// PULSE_LO | step_o low for one half-period, counts a completed step
// SETTLE   | post-move idle gap, motor still enabled
// DONE     | one-cycle done pulse, busy dropped
module motor_step_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int STEPS_PER_MV = 50,
  parameter int HALF_PER     = 25000,
  parameter int SETTLE       = 500000
) (
  input  logic clk,
  input  logic rst,
  motor_step_sequencer_if.slave bus
);

  localparam int TMR_MAX = (SETTLE > HALF_PER) ? SETTLE : HALF_PER;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = $clog2(STEPS_PER_MV + 1);

  localparam logic [TMR_W-1:0]  HALF_LD    = TMR_W'(HALF_PER - 1);
  localparam logic [TMR_W-1:0]  SETTLE_LD  = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
  localparam logic [CNT_W-1:0]  STEPS_LAST = CNT_W'(STEPS_PER_MV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_PULSE_HI, S_PULSE_LO, S_SETTLE, S_DONE
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] step_cnt;
  logic [2:0]       sel;
  logic [ADDR_W:0]  len_r;

  logic [2:0] motor;
  logic       last_entry;
  logic       tmr_zero;
  logic       moving;

  assign motor      = bus.q_data[2:0];
  assign last_entry = ({1'b0, bus.q_addr} == (len_r - LEN_ONE));
  assign tmr_zero   = (tmr == '0);
  assign moving     = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      tmr            <= '0;
      step_cnt       <= '0;
      sel            <= '0;
      len_r          <= '0;
      bus.q_addr     <= '0;
      bus.step_o     <= '0;
      bus.dir_o      <= 1'b0;
      bus.motor_en_o <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.moves_done <= '0;
    end else begin
      bus.done <= 1'b0;
      if (moving && bus.abort) begin
        state          <= S_DONE;
        bus.step_o     <= '0;
        bus.motor_en_o <= '0;
        bus.busy       <= 1'b0;
        bus.done       <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              len_r          <= bus.q_len;
              bus.q_addr     <= '0;
              bus.err        <= 1'b0;
              bus.moves_done <= '0;
              if (bus.q_len != '0) begin
                state    <= S_LOAD;
                bus.busy <= 1'b1;
              end else begin
                state    <= S_DONE;
                bus.done <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            if (motor == 3'd0) begin
              state    <= S_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else if (motor == 3'd7) begin
              bus.err <= 1'b1;
              if (last_entry) begin
                state    <= S_DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
              end else begin
                bus.q_addr <= bus.q_addr + ADDR_ONE;
              end
            end else begin
              sel            <= motor - 3'd1;
              bus.dir_o      <= bus.q_data[3];
              bus.motor_en_o <= 6'b000001 << (motor - 3'd1);
              step_cnt       <= '0;
              tmr            <= HALF_LD;
              state          <= S_SETUP;
            end
          end
          S_SETUP: begin
            if (tmr_zero) begin
              bus.step_o <= 6'b000001 << sel;
              tmr        <= HALF_LD;
              state      <= S_PULSE_HI;
            end else begin
              tmr <= tmr - TMR_ONE;
            end
          end
          S_PULSE_HI: begin
            if (tmr_zero) begin
              bus.step_o <= '0;
              tmr        <= HALF_LD;
              state      <= S_PULSE_LO;
            end else begin
              tmr <= tmr - TMR_ONE;
            end
          end
          S_PULSE_LO: begin
            if (tmr_zero) begin
              step_cnt <= step_cnt + CNT_ONE;
              if (step_cnt == STEPS_LAST) begin
                tmr   <= SETTLE_LD;
                state <= S_SETTLE;
              end else begin
                bus.step_o <= 6'b000001 << sel;
                tmr        <= HALF_LD;
                state      <= S_PULSE_HI;
              end
            end else begin
              tmr <= tmr - TMR_ONE;
            end
          end
          S_SETTLE: begin
            if (tmr_zero) begin
              bus.moves_done <= bus.moves_done + LEN_ONE;
              bus.motor_en_o <= '0;
              if (last_entry) begin
                state    <= S_DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
              end else begin
                bus.q_addr <= bus.q_addr + ADDR_ONE;
                state      <= S_LOAD;
              end
            end else begin
              tmr <= tmr - TMR_ONE;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
